file_stream_reader: RTL

Read-side companion to the CPU's file RAM store path. On a start pulse it reads `length` bytes from the 256-byte file RAM, starting at `base_addr`. It then streams them, one at a time, into the UART transmitter through its start/busy handshake. Once this block exists, the CPU's inline READ_FILE state is replaced by a start/done exchange with it.

---
 rtl/file_stream_reader_pkg.sv | 20 ++
 rtl/file_stream_reader_nibble_to_ascii.sv | 13 +
 rtl/file_stream_reader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/file_stream_reader_pkg.sv
// Shared types and constants for the file RAM stream reader and its hex formatter.
package file_stream_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_SEND  = 3'd3,
    S_ACK   = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [7:0] ASCII_SPACE     = 8'h20;
  localparam logic [7:0] ASCII_ZERO      = 8'h30;
  localparam logic [7:0] ASCII_HEX_A_OFS = 8'h37;

  localparam int ACK_TIMEOUT_DEF = 4;

endpackage

// File: rtl/file_stream_reader_nibble_to_ascii.sv
// Combinational 4-bit nibble to upper-case ASCII hex character; zero latency, no flow control.
module nibble_to_ascii
  import file_stream_reader_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  logic [7:0] w_nib;
  assign w_nib   = {4'd0, i_nibble};
  assign o_ascii = (i_nibble < 4'd10) ? (ASCII_ZERO + w_nib) : (ASCII_HEX_A_OFS + w_nib);

endmodule

// File: rtl/file_stream_reader.sv
// Streams length bytes from file RAM at base_addr to the UART tx; first tx_start 3 clocks after start.
// Stalls in SEND while tx_busy is high; FILE_STREAM_HEX_EN sends each byte as "HH " instead of raw.
module file_stream_reader
  import file_stream_reader_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_length,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_ram_addr,
  input  logic [7:0]        i_ram_rdata,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_busy
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [TW-1:0]     r_tmo;
  logic [7:0]        r_byte;
  logic [7:0]        r_tx_data;
  logic              r_tx_start;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic [7:0]        w_tx_char;

  assign w_idx_nxt = r_idx + ADDR_W'(1);

`ifdef FILE_STREAM_HEX_EN
  logic [1:0] r_chr;
  logic [7:0] w_hi;
  logic [7:0] w_lo;

  nibble_to_ascii u_hi (.i_nibble(r_byte[7:4]), .o_ascii(w_hi));
  nibble_to_ascii u_lo (.i_nibble(r_byte[3:0]), .o_ascii(w_lo));

  assign w_tx_char = (r_chr == 2'd0) ? w_hi : (r_chr == 2'd1) ? w_lo : ASCII_SPACE;
`else
  assign w_tx_char = r_byte;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_ram_addr <= '0;
      r_tmo      <= '0;
      r_byte     <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef FILE_STREAM_HEX_EN
      r_chr      <= 2'd0;
`endif
    end else begin
      r_tx_start <= 1'b0;
      r_done     <= 1'b0;
      // Abort beats everything, including a start arriving in IDLE.
      if (i_abort) begin
        if (r_state != S_IDLE) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_base <= i_base_addr;
              r_len  <= i_length;
              r_idx  <= '0;
              r_busy <= 1'b1;
              if (i_length == '0) begin
                r_state <= S_DONE;
              end else begin
                r_ram_addr <= i_base_addr;
                r_state    <= S_ADDR;
              end
            end
          end
          S_ADDR: r_state <= S_DATA;
          S_DATA: begin
            r_byte  <= i_ram_rdata;
`ifdef FILE_STREAM_HEX_EN
            r_chr   <= 2'd0;
`endif
            r_state <= S_SEND;
          end
          S_SEND: begin
            if (!i_tx_busy) begin
              r_tx_data  <= w_tx_char;
              r_tx_start <= 1'b1;
              r_tmo      <= '0;
              r_state    <= S_ACK;
            end
          end
          S_ACK: begin
            if (i_tx_busy || (r_tmo == TMO_LAST)) begin
              r_state <= S_DRAIN;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          S_DRAIN: begin
            if (!i_tx_busy) begin
`ifdef FILE_STREAM_HEX_EN
              if (r_chr != 2'd2) begin
                r_chr   <= r_chr + 2'd1;
                r_state <= S_SEND;
              end else
`endif
              begin
                r_idx <= w_idx_nxt;
                if (w_idx_nxt == r_len) begin
                  r_state <= S_DONE;
                end else begin
                  r_ram_addr <= r_base + w_idx_nxt;
                  r_state    <= S_ADDR;
                end
              end
            end
          end
          S_DONE: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_ram_addr = r_ram_addr;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;

endmodule
